// File: rtl/ct_rtu_pst_pkg.sv
// Shared constants and helpers for the RTU PST physical vector register allocator.
package ct_rtu_pst_pkg;

  localparam int PREG_NUM  = 64;
  localparam int PREG_W    = 6;
  localparam int ALLOC_NUM = 4;
  localparam int ARCH_NUM  = 32;
  localparam int CNT_W     = PREG_W + 1;

  // Pregs below ARCH_NUM hold architectural state out of reset; the rest are free.
  localparam logic [PREG_NUM-1:0] RESET_FREE_BITMAP =
    {{(PREG_NUM-ARCH_NUM){1'b1}}, {ARCH_NUM{1'b0}}};

  // Number of set bits in a preg bitmap; 0..64 needs CNT_W bits.
  function automatic logic [CNT_W-1:0] preg_popcount(input logic [PREG_NUM-1:0] bits);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < PREG_NUM; i++) begin
      cnt = cnt + CNT_W'(bits[i]);
    end
    return cnt;
  endfunction

  // Encode a one-hot (or all-zero) preg vector into its index; zero maps to 0.
  function automatic logic [PREG_W-1:0] preg_onehot_to_idx(input logic [PREG_NUM-1:0] onehot);
    logic [PREG_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < PREG_NUM; i++) begin
      if (onehot[i]) begin
        idx = idx | PREG_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/ct_rtu_pst_preg_pick4.sv
// Combinational find-first-N picker: returns the ALLOC_NUM lowest-index free pregs,
// each with a valid bit and a one-hot mask used to clear it from the free bitmap.
module ct_rtu_pst_preg_pick4
  import ct_rtu_pst_pkg::*;
(
  input  logic [PREG_NUM-1:0]  free_bitmap,
  output logic [ALLOC_NUM-1:0] pick_vld,
  output logic [PREG_W-1:0]    pick_idx    [ALLOC_NUM],
  output logic [PREG_NUM-1:0]  pick_onehot [ALLOC_NUM]
);

  logic [PREG_NUM-1:0] remain;
  logic [PREG_NUM-1:0] lowest;

  // Peel off the lowest set bit ALLOC_NUM times, removing each pick before the next.
  always_comb begin
    remain = free_bitmap;
    lowest = '0;
    for (int k = 0; k < ALLOC_NUM; k++) begin
      lowest         = remain & (~remain + PREG_NUM'(1));
      pick_onehot[k] = lowest;
      pick_vld[k]    = |lowest;
      pick_idx[k]    = preg_onehot_to_idx(lowest);
      remain         = remain & ~lowest;
    end
  end

endmodule

// File: rtl/ct_rtu_pst_vreg_alloc_ctrl.sv
// Free-list allocator for the 64-entry physical vreg pool: holds the free bitmap,
// keeps four registered allocation slots topped up for IDU rename, returns pregs on
// retire-release and restores the free state from the recover mask on flush.
module ct_rtu_pst_vreg_alloc_ctrl
  import ct_rtu_pst_pkg::*;
(
  input  logic                forever_cpuclk,
  input  logic                cpurst,
  input  logic                idu_rtu_ir_xreg0_alloc_vld,
  input  logic                idu_rtu_ir_xreg1_alloc_vld,
  input  logic                idu_rtu_ir_xreg2_alloc_vld,
  input  logic                idu_rtu_ir_xreg3_alloc_vld,
  input  logic                rob_pst_release_vld,
  input  logic [PREG_NUM-1:0] idu_rtu_pst_xreg_dealloc_mask,
  input  logic                rtu_yy_xx_flush,
  input  logic [PREG_NUM-1:0] rtu_pst_recover_free_mask,
  output logic [PREG_W-1:0]   rtu_idu_alloc_xreg0,
  output logic                rtu_idu_alloc_xreg0_vld,
  output logic [PREG_W-1:0]   rtu_idu_alloc_xreg1,
  output logic                rtu_idu_alloc_xreg1_vld,
  output logic [PREG_W-1:0]   rtu_idu_alloc_xreg2,
  output logic                rtu_idu_alloc_xreg2_vld,
  output logic [PREG_W-1:0]   rtu_idu_alloc_xreg3,
  output logic                rtu_idu_alloc_xreg3_vld,
  output logic [CNT_W-1:0]    rtu_pst_free_cnt
);

  logic [PREG_NUM-1:0]  free_bitmap;
  logic [PREG_NUM-1:0]  free_bitmap_nxt;
  logic [CNT_W-1:0]     free_cnt;
  logic [ALLOC_NUM-1:0] slot_vld;
  logic [ALLOC_NUM-1:0] slot_vld_nxt;
  logic [PREG_W-1:0]    slot_preg     [ALLOC_NUM];
  logic [PREG_W-1:0]    slot_preg_nxt [ALLOC_NUM];
  logic [ALLOC_NUM-1:0] alloc_vld;
  logic [ALLOC_NUM-1:0] pick_vld;
  logic [PREG_W-1:0]    pick_idx    [ALLOC_NUM];
  logic [PREG_NUM-1:0]  pick_onehot [ALLOC_NUM];
  logic [PREG_NUM-1:0]  pick_clear;
  logic [PREG_NUM-1:0]  release_mask;
  logic [PREG_NUM-1:0]  staged_mask;
  logic [1:0]           rank;

  assign alloc_vld = {idu_rtu_ir_xreg3_alloc_vld, idu_rtu_ir_xreg2_alloc_vld,
                      idu_rtu_ir_xreg1_alloc_vld, idu_rtu_ir_xreg0_alloc_vld};

  assign release_mask = rob_pst_release_vld ? idu_rtu_pst_xreg_dealloc_mask : '0;

  // The picker only ever looks at the registered bitmap, so same-cycle releases wait a cycle.
  ct_rtu_pst_preg_pick4 u_pick (
    .free_bitmap (free_bitmap),
    .pick_vld    (pick_vld),
    .pick_idx    (pick_idx),
    .pick_onehot (pick_onehot)
  );

  // Hand the k-th empty slot (ascending) the k-th pick; only handed-out picks leave the bitmap.
  always_comb begin
    rank       = '0;
    pick_clear = '0;
    for (int i = 0; i < ALLOC_NUM; i++) begin
      slot_vld_nxt[i]  = slot_vld[i];
      slot_preg_nxt[i] = slot_preg[i];
      if (!slot_vld[i] || alloc_vld[i]) begin
        slot_vld_nxt[i]  = pick_vld[rank];
        slot_preg_nxt[i] = pick_idx[rank];
        pick_clear       = pick_clear | pick_onehot[rank];
        rank             = rank + 2'd1;
      end
    end
    free_bitmap_nxt = (free_bitmap & ~pick_clear) | release_mask;
    if (rtu_yy_xx_flush) begin
      free_bitmap_nxt = rtu_pst_recover_free_mask;
      slot_vld_nxt    = '0;
      for (int i = 0; i < ALLOC_NUM; i++) begin
        slot_preg_nxt[i] = '0;
      end
    end
  end

  // Bitmap, slots and the free count all advance together on the clock edge.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      free_bitmap <= RESET_FREE_BITMAP;
      free_cnt    <= CNT_W'(PREG_NUM - ARCH_NUM);
      slot_vld    <= '0;
      for (int i = 0; i < ALLOC_NUM; i++) begin
        slot_preg[i] <= '0;
      end
    end else begin
      free_bitmap <= free_bitmap_nxt;
      free_cnt    <= preg_popcount(free_bitmap_nxt);
      slot_vld    <= slot_vld_nxt;
      for (int i = 0; i < ALLOC_NUM; i++) begin
        slot_preg[i] <= slot_preg_nxt[i];
      end
    end
  end

  assign rtu_idu_alloc_xreg0     = slot_preg[0];
  assign rtu_idu_alloc_xreg1     = slot_preg[1];
  assign rtu_idu_alloc_xreg2     = slot_preg[2];
  assign rtu_idu_alloc_xreg3     = slot_preg[3];
  assign rtu_idu_alloc_xreg0_vld = slot_vld[0];
  assign rtu_idu_alloc_xreg1_vld = slot_vld[1];
  assign rtu_idu_alloc_xreg2_vld = slot_vld[2];
  assign rtu_idu_alloc_xreg3_vld = slot_vld[3];
  assign rtu_pst_free_cnt        = free_cnt;

  // Pregs currently sitting in a valid slot; used to catch double-free and lost pregs.
  always_comb begin
    staged_mask = '0;
    for (int i = 0; i < ALLOC_NUM; i++) begin
      if (slot_vld[i]) begin
        staged_mask[slot_preg[i]] = 1'b1;
      end
    end
  end

  a_alloc_on_empty_slot: assert property (@(posedge forever_cpuclk)
    disable iff (cpurst || rtu_yy_xx_flush) (alloc_vld & ~slot_vld) == '0);

  a_release_not_allocated: assert property (@(posedge forever_cpuclk)
    disable iff (cpurst || rtu_yy_xx_flush) (release_mask & (free_bitmap | staged_mask)) == '0);

  a_staged_not_free: assert property (@(posedge forever_cpuclk)
    disable iff (cpurst) (staged_mask & free_bitmap) == '0);

  a_free_cnt_matches: assert property (@(posedge forever_cpuclk)
    disable iff (cpurst) free_cnt == preg_popcount(free_bitmap));

endmodule

// File: tb/tb_ct_rtu_pst_vreg_alloc_ctrl.sv
// Directed self-checking bench for the physical vreg allocator.
module tb_ct_rtu_pst_vreg_alloc_ctrl;
  import ct_rtu_pst_pkg::*;

  logic                forever_cpuclk = 1'b0;
  logic                cpurst;
  logic [3:0]          alloc;
  logic                rob_pst_release_vld;
  logic [PREG_NUM-1:0] dealloc_mask;
  logic                flush;
  logic [PREG_NUM-1:0] recover_mask;
  logic [PREG_W-1:0]   preg0, preg1, preg2, preg3;
  logic                vld0, vld1, vld2, vld3;
  logic [CNT_W-1:0]    free_cnt;

  logic [PREG_W-1:0]   obs_preg [4];
  logic [3:0]          obs_vld;
  logic [PREG_W-1:0]   exp_preg [4];
  logic [3:0]          exp_vld;

  int checks = 0;
  int errors = 0;

  always #5 forever_cpuclk = ~forever_cpuclk;

  ct_rtu_pst_vreg_alloc_ctrl dut (
    .forever_cpuclk                (forever_cpuclk),
    .cpurst                        (cpurst),
    .idu_rtu_ir_xreg0_alloc_vld    (alloc[0]),
    .idu_rtu_ir_xreg1_alloc_vld    (alloc[1]),
    .idu_rtu_ir_xreg2_alloc_vld    (alloc[2]),
    .idu_rtu_ir_xreg3_alloc_vld    (alloc[3]),
    .rob_pst_release_vld           (rob_pst_release_vld),
    .idu_rtu_pst_xreg_dealloc_mask (dealloc_mask),
    .rtu_yy_xx_flush               (flush),
    .rtu_pst_recover_free_mask     (recover_mask),
    .rtu_idu_alloc_xreg0           (preg0),
    .rtu_idu_alloc_xreg0_vld       (vld0),
    .rtu_idu_alloc_xreg1           (preg1),
    .rtu_idu_alloc_xreg1_vld       (vld1),
    .rtu_idu_alloc_xreg2           (preg2),
    .rtu_idu_alloc_xreg2_vld       (vld2),
    .rtu_idu_alloc_xreg3           (preg3),
    .rtu_idu_alloc_xreg3_vld       (vld3),
    .rtu_pst_free_cnt              (free_cnt)
  );

  assign obs_preg[0] = preg0;
  assign obs_preg[1] = preg1;
  assign obs_preg[2] = preg2;
  assign obs_preg[3] = preg3;
  assign obs_vld     = {vld3, vld2, vld1, vld0};

  // Advance one clock and settle just after the edge, away from it.
  task automatic cycle();
    @(posedge forever_cpuclk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc               = '0;
    rob_pst_release_vld = 1'b0;
    dealloc_mask        = '0;
    flush               = 1'b0;
    recover_mask        = '0;
  endtask

  task automatic test_reset();
    cpurst = 1'b1;
    idle_inputs();
    cycle();
    cycle();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_vld[i] !== 1'b0 || obs_preg[i] !== 6'd0) begin
        errors++;
        $display("[TB] FAIL reset_slot%0d: got vld=%b preg=%0d, want vld=0 preg=0", i, obs_vld[i], obs_preg[i]);
      end
    end
    checks++;
    if (free_cnt !== 7'd32) begin
      errors++;
      $display("[TB] FAIL reset_free_cnt: got %0d, want 32", free_cnt);
    end
    cpurst = 1'b0;
    cycle();
    cycle();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_vld[i] !== 1'b1 || obs_preg[i] !== PREG_W'(32 + i)) begin
        errors++;
        $display("[TB] FAIL init_slot%0d: got vld=%b preg=%0d, want vld=1 preg=%0d", i, obs_vld[i], obs_preg[i], 32 + i);
      end
    end
    checks++;
    if (free_cnt !== 7'd28) begin
      errors++;
      $display("[TB] FAIL init_free_cnt: got %0d, want 28", free_cnt);
    end
  endtask

  task automatic test_partial_consume();
    alloc = 4'b0101;
    cycle();
    idle_inputs();
    exp_preg[0] = 6'd36; exp_preg[1] = 6'd33; exp_preg[2] = 6'd37; exp_preg[3] = 6'd35;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_vld[i] !== 1'b1 || obs_preg[i] !== exp_preg[i]) begin
        errors++;
        $display("[TB] FAIL partial_slot%0d: got vld=%b preg=%0d, want vld=1 preg=%0d", i, obs_vld[i], obs_preg[i], exp_preg[i]);
      end
    end
    checks++;
    if (free_cnt !== 7'd26) begin
      errors++;
      $display("[TB] FAIL partial_free_cnt: got %0d, want 26", free_cnt);
    end
  endtask

  task automatic test_exhaust_and_release();
    int exp_cnt;
    for (int c = 1; c <= 8; c++) begin
      alloc = (c == 8) ? 4'b0011 : 4'b1111;
      cycle();
      idle_inputs();
      for (int i = 0; i < 4; i++) begin
        if (c <= 6) begin
          exp_vld[i] = 1'b1; exp_preg[i] = PREG_W'(38 + 4 * (c - 1) + i);
        end else if (c == 7 && i < 2) begin
          exp_vld[i] = 1'b1; exp_preg[i] = PREG_W'(62 + i);
        end else begin
          exp_vld[i] = 1'b0; exp_preg[i] = '0;
        end
      end
      exp_cnt = (c <= 6) ? 26 - 4 * c : 0;
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_vld[i] !== exp_vld[i] || (exp_vld[i] && obs_preg[i] !== exp_preg[i])) begin
          errors++;
          $display("[TB] FAIL exhaust_c%0d_slot%0d: got vld=%b preg=%0d, want vld=%b preg=%0d", c, i, obs_vld[i], obs_preg[i], exp_vld[i], exp_preg[i]);
        end
      end
      checks++;
      if (free_cnt !== CNT_W'(exp_cnt)) begin
        errors++;
        $display("[TB] FAIL exhaust_c%0d_free_cnt: got %0d, want %0d", c, free_cnt, exp_cnt);
      end
    end
    rob_pst_release_vld = 1'b1;
    dealloc_mask        = 64'd1 << 5;
    cycle();
    idle_inputs();
    checks++;
    if (free_cnt !== 7'd1 || obs_vld !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL release_t1: got free_cnt=%0d vld=%b, want free_cnt=1 vld=0000", free_cnt, obs_vld);
    end
    cycle();
    checks++;
    if (obs_vld !== 4'b0001 || preg0 !== 6'd5 || free_cnt !== 7'd0) begin
      errors++;
      $display("[TB] FAIL release_t2: got vld=%b preg0=%0d free_cnt=%0d, want vld=0001 preg0=5 free_cnt=0", obs_vld, preg0, free_cnt);
    end
  endtask

  task automatic test_flush();
    flush               = 1'b1;
    recover_mask        = 64'hFFFF_0000_0000_0000;
    alloc               = 4'b0001;
    rob_pst_release_vld = 1'b1;
    dealloc_mask        = 64'd1 << 6;
    cycle();
    idle_inputs();
    checks++;
    if (obs_vld !== 4'b0000 || free_cnt !== 7'd16) begin
      errors++;
      $display("[TB] FAIL flush_t1: got vld=%b free_cnt=%0d, want vld=0000 free_cnt=16", obs_vld, free_cnt);
    end
    cycle();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_vld[i] !== 1'b1 || obs_preg[i] !== PREG_W'(48 + i)) begin
        errors++;
        $display("[TB] FAIL flush_t2_slot%0d: got vld=%b preg=%0d, want vld=1 preg=%0d", i, obs_vld[i], obs_preg[i], 48 + i);
      end
    end
    checks++;
    if (free_cnt !== 7'd12) begin
      errors++;
      $display("[TB] FAIL flush_t2_free_cnt: got %0d, want 12", free_cnt);
    end
  endtask

  task automatic test_reset_mid_stream();
    alloc = 4'b0010;
    cycle();
    checks++;
    if (preg1 !== 6'd52 || vld1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_pre: got vld1=%b preg1=%0d, want vld1=1 preg1=52", vld1, preg1);
    end
    alloc  = 4'b0001;
    cpurst = 1'b1;
    cycle();
    cpurst = 1'b0;
    idle_inputs();
    checks++;
    if (obs_vld !== 4'b0000 || free_cnt !== 7'd32) begin
      errors++;
      $display("[TB] FAIL midreset_state: got vld=%b free_cnt=%0d, want vld=0000 free_cnt=32", obs_vld, free_cnt);
    end
    cycle();
    cycle();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_vld[i] !== 1'b1 || obs_preg[i] !== PREG_W'(32 + i)) begin
        errors++;
        $display("[TB] FAIL midreset_slot%0d: got vld=%b preg=%0d, want vld=1 preg=%0d", i, obs_vld[i], obs_preg[i], 32 + i);
      end
    end
    checks++;
    if (free_cnt !== 7'd28) begin
      errors++;
      $display("[TB] FAIL midreset_free_cnt: got %0d, want 28", free_cnt);
    end
  endtask

  task automatic test_release_and_pick();
    alloc               = 4'b0001;
    rob_pst_release_vld = 1'b1;
    dealloc_mask        = 64'd1 << 7;
    cycle();
    idle_inputs();
    checks++;
    if (preg0 !== 6'd36 || vld0 !== 1'b1 || free_cnt !== 7'd28) begin
      errors++;
      $display("[TB] FAIL relpick_same_cycle: got vld0=%b preg0=%0d free_cnt=%0d, want vld0=1 preg0=36 free_cnt=28", vld0, preg0, free_cnt);
    end
    alloc = 4'b0010;
    cycle();
    idle_inputs();
    checks++;
    if (preg1 !== 6'd7 || vld1 !== 1'b1 || free_cnt !== 7'd27) begin
      errors++;
      $display("[TB] FAIL relpick_lowest: got vld1=%b preg1=%0d free_cnt=%0d, want vld1=1 preg1=7 free_cnt=27", vld1, preg1, free_cnt);
    end
  endtask

  initial begin
    cpurst = 1'b1;
    idle_inputs();
    test_reset();
    test_partial_consume();
    test_exhaust_and_release();
    test_flush();
    test_reset_mid_stream();
    test_release_and_pick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
